// File: rtl/pt_checker.sv
// pt_checker: scans a length-prefixed plaintext RAM and reports whether every message byte is printable ASCII
module pt_checker (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] pt_rddata,
  output logic       rdy,
  output logic [7:0] pt_addr,
  output logic       key_valid,
  output logic [7:0] fail_addr
);
  typedef enum logic [2:0] {IDLE, LEN_WAIT, LEN_READ, BYTE_WAIT, BYTE_READ} state_t;
  state_t state;
  logic [7:0] len;
  logic printable;
  // printable ASCII window, unsigned compare
  always_comb printable = (pt_rddata >= 8'h20) && (pt_rddata <= 8'h7e);
  // scan FSM: each RAM read takes a wait cycle then a read cycle; stops early on the first bad byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rdy       <= 1'b1;
      key_valid <= 1'b0;
      fail_addr <= 8'd0;
      pt_addr   <= 8'd0;
      len       <= 8'd0;
    end else begin
      case (state)
        IDLE: if (en) begin
          rdy       <= 1'b0;
          key_valid <= 1'b0;
          fail_addr <= 8'd0;
          pt_addr   <= 8'd0;
          state     <= LEN_WAIT;
        end
        LEN_WAIT: state <= LEN_READ;
        LEN_READ: begin
          len <= pt_rddata;
          if (pt_rddata == 8'd0) begin
            key_valid <= 1'b1;
            rdy       <= 1'b1;
            state     <= IDLE;
          end else begin
            pt_addr <= 8'd1;
            state   <= BYTE_WAIT;
          end
        end
        BYTE_WAIT: state <= BYTE_READ;
        BYTE_READ: if (!printable) begin
          fail_addr <= pt_addr;
          rdy       <= 1'b1;
          state     <= IDLE;
        end else if (pt_addr == len) begin
          key_valid <= 1'b1;
          rdy       <= 1'b1;
          state     <= IDLE;
        end else begin
          pt_addr <= pt_addr + 8'd1;
          state   <= BYTE_WAIT;
        end
        default: begin
          rdy   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
